adder_seq_ctrl: RTL and testbench
=================================

// Module: adder_seq_ctrl
// PURPOSE
//   Sequencer that computes WIDTH-bit additions on the existing 4-bit Adder slice.
//   - Captures wide operands through a valid/ready handshake.
//   - Steps the slice one nibble per cycle, LSB first, chaining carry in a register.
//   - Returns the WIDTH-bit result through a second valid/ready handshake.
//   - Sits between wide-operand producers and the narrow shared Adder datapath.
// PARAMETERS
//   WIDTH    16   operand/result width; must be a multiple of 4, >= 8
//   NIB      WIDTH/4 (localparam)   number of slice passes per operation
// PORTS
//   CLK        in   1      rising-edge clock
//   RST_N      in   1      synchronous, active-low reset
//   IN_VALID   in   1      operands presented
//   IN_READY   out  1      block accepts operands (high only in IDLE, low while RST_N=0)
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   CIN        in   1      carry into bit 0
//   SUB        in   1      subtract select (port exists only with ADDER_SEQ_SUB_EN)
//   OUT_VALID  out  1      result valid
//   OUT_READY  in   1      consumer takes result
//   SUM        out  WIDTH  result
//   COUT       out  1      carry out of bit WIDTH-1
//   BUSY       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset: on any edge with RST_N=0 -> state IDLE, idx=0, carry=0, SUM=0, COUT=0, OUT_VALID=0.
//     Reset overrides every other event, including mid-RUN. A partial result is discarded.
//   FSM IDLE -> RUN -> DONE -> IDLE. 2-bit state encoding.
//   IDLE:
//     - Accept edge is IN_VALID & IN_READY.
//     - On accept: latch A and B, set carry=CIN, set idx=0, go to RUN.
//     - IN_VALID without IN_READY is ignored.
//   RUN: each edge performs one slice pass.
//     - Slice inputs: A_r[4*idx+:4], B_r[4*idx+:4], carry.
//     - SUM[4*idx+:4] <= slice SUM; carry <= slice COUT; idx <= idx+1.
//     - When idx==NIB-1: COUT <= slice COUT, go to DONE.
//   DONE:
//     - OUT_VALID=1; SUM and COUT held stable until OUT_READY=1.
//     - On OUT_READY=1, go to IDLE.
//     - IN_READY is 0 here, so accept and output handshakes never overlap.
//   Latency: OUT_VALID rises exactly NIB edges after the accept edge.
//   Throughput: one operation per NIB+2 cycles with OUT_READY tied high.
//   Arithmetic: SUM = (A + B + CIN) mod 2^WIDTH. COUT = bit WIDTH of the full sum.
//   idx is $clog2(NIB) bits wide and never wraps past NIB-1.
//   SUM nibbles not yet written in RUN keep their previous values; only DONE values are defined.
// CONFIGURATION
//   ADDER_SEQ_SUB_EN defined:
//     - SUB port exists and is latched at accept.
//     - SUB=1: slice B input = ~B_r nibble, initial carry = 1, CIN ignored.
//       SUM = A - B mod 2^WIDTH; COUT=1 means no borrow.
//   ADDER_SEQ_SUB_EN undefined: no SUB port, add-only.
// STRUCTURE
//   Shared package adder_seq_pkg:
//     - state typedef {IDLE, RUN, DONE}
//     - SLICE_W = 4 constant
//   One sub-module instance: Adder (existing 4-bit slice, ports A, B, CIN, SUM, COUT).
//   All sequencing stays in this module.
// TESTING (WIDTH=16)
//   1 A=16'h00FF, B=16'h0001, CIN=0 -> SUM=16'h0100, COUT=0; OUT_VALID 4 edges after accept.
//   2 A=16'hFFFF, B=16'h0000, CIN=1 -> SUM=16'h0000, COUT=1 (carry ripples through all 4 passes).
//   3 Result pending, OUT_READY=0 for 5 cycles, IN_VALID=1 throughout ->
//     SUM, COUT and OUT_VALID stable; IN_READY=0; no second op accepted.
//   4 RST_N=0 after 2 RUN edges -> next edge: IDLE, OUT_VALID=0, SUM=0, COUT=0.
//     A following op 16'h1234 + 16'h4321 -> SUM=16'h5555, COUT=0.
//   5 ADDER_SEQ_SUB_EN: A=16'h0005, B=16'h0007, SUB=1 -> SUM=16'hFFFE, COUT=0.
//     A=16'h0007, B=16'h0005 -> SUM=16'h0002, COUT=1.
//   6 Two back-to-back ops, OUT_READY=1 -> IN_READY high the edge after each output handshake.
//     Results 16'hA5A5 + 16'h5A5B = 16'h0000/COUT=1, and 16'h8000 + 16'h8000 = 16'h0000/COUT=1.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared state type and slice width for the adder sequencer
package adder_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;
endpackage

// File: rtl/Adder.sv
// rtl/Adder.sv - 4-bit ripple adder slice shared by the wide-add sequencer
module Adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       COUT
);
  assign {COUT, SUM} = 5'(A) + 5'(B) + 5'(CIN);
endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - WIDTH-bit add sequenced one nibble per cycle over a 4-bit slice
// Optional subtract support when ADDER_SEQ_SUB_EN is defined.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             SUB,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             BUSY
);
  localparam int NIB   = WIDTH / SLICE_W;
  localparam int IDX_W = $clog2(NIB);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  logic [WIDTH-1:0]     a_r, b_r;
  logic                 sub_r;
  logic [WIDTH-1:0]     sum_r;
  logic                 cout_r;
  logic                 accept, last, init_carry, sub_in;
  logic [SLICE_W-1:0]   a_nib, b_nib, b_in, s_sum;
  logic                 s_cout;

`ifdef ADDER_SEQ_SUB_EN
  assign sub_in = SUB;
`else
  assign sub_in = 1'b0;
`endif

  assign IN_READY   = RST_N && (state == IDLE);
  assign accept     = IN_VALID && IN_READY;
  assign last       = (idx == IDX_W'(NIB - 1));
  // Subtraction is A + ~B + 1, so the caller's carry is ignored then.
  assign init_carry = sub_in ? 1'b1 : CIN;

  assign a_nib = a_r[idx*SLICE_W +: SLICE_W];
  assign b_nib = b_r[idx*SLICE_W +: SLICE_W];
  assign b_in  = sub_r ? ~b_nib : b_nib;

  Adder u_slice (
    .A    (a_nib),
    .B    (b_in),
    .CIN  (carry),
    .SUM  (s_sum),
    .COUT (s_cout)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      a_r   <= A;
      b_r   <= B;
      sub_r <= sub_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idx    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= '0;
            carry <= init_carry;
          end
        end
        RUN: begin
          sum_r[idx*SLICE_W +: SLICE_W] <= s_sum;
          carry                         <= s_cout;
          // idx parks on the last nibble rather than wrapping.
          if (last) cout_r <= s_cout;
          else      idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign OUT_VALID = (state == DONE);
  assign BUSY      = (state == RUN) || (state == DONE);
  assign SUM       = sum_r;
  assign COUT      = cout_r;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - vector table, corner sequences and random ops against a sum model
module tb_adder_seq_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .A         (a),
    .B         (b),
    .CIN       (cin),
`ifdef ADDER_SEQ_SUB_EN
    .SUB       (sub),
`endif
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .SUM       (sum),
    .COUT      (cout),
    .BUSY      (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: whole-word integer arithmetic, subtraction as a true difference.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s);
    longint unsigned t;
    if (s) begin
      t = (longint'(x) - longint'(y)) & ((64'd1 << W) - 1);
      return {(x >= y), t[W-1:0]};
    end
    t = longint'(x) + longint'(y) + longint'(ci);
    return t[W:0];
  endfunction

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, input string tag);
    int n;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input logic [W-1:0] es, input logic ec, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input logic [W-1:0] es, input logic ec, input string tag);
    start_op(ta, tb_, tc, ts, tag);
    finish_op(es, ec, tag);
  endtask

  initial begin
    vec_t         vecs[8];
    logic [W:0]   m;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[3] = '{16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].sum, vecs[i].cout,
             $sformatf("vec%0d", i));

    // Result held while the consumer stalls and a producer keeps pushing.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, "stall");
    repeat (4) @(negedge clk);
    check("stall_done", 32'(out_valid), 32'd1);
    a = 16'hDEAD; b = 16'hBEEF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_sum", 32'(sum), 32'h3333);
      check("stall_cout", 32'(cout), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_no_second_busy", 32'(busy), 32'd0);
    check("stall_no_second_valid", 32'(out_valid), 32'd0);

    // Reset lands after two slice passes.
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "midrst");
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_busy_off", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "postrst");

`ifdef ADDER_SEQ_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub_borrow");
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, "sub_noborrow");
`endif

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef ADDER_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      m = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, m[W-1:0], m[W], $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
